// File: rtl/toa_fine_code_generator.sv
// toa_fine_code_generator
//   Builds the 63-bit delay-line phase word that the TOA fine-phase encoder
//   consumes, for self-test and calibration of that encoder. A word for value
//   N has RUN_LEN consecutive ones starting at bit N (wrapping mod 63); N = 63
//   gives an all-zero word whose expected encoder result is 6'h3F.
//   Words are launched either one at a time (mode 01, valid/ready load) or as
//   an auto-incrementing sweep (mode 10), held for hold_cycles+1 cycles, and
//   may carry one inverted ("bubble") bit.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   mode           00 idle, 01 single, 10 sweep, 11 behaves as 00
//   in_valid       single: value offered / sweep: start strobe
//   in_ready       high only in IDLE with mode 01
//   in_value       single value or sweep start value (63 starts a sweep at 0)
//   hold_cycles    word is presented for hold_cycles+1 cycles (sampled at launch)
//   inj_en/inj_bit bubble request, sampled when a word is built (63 = none)
//   code_out       phase word (holds its last value when not valid)
//   code_valid     high during the hold window of a launched word
//   code_value     nominal N of code_out (expected encoder output)
//   code_injected  current word carries a bubble
//   sweep_wrap     high on the first valid cycle of a word 0 reached by 62->0
//   dbg_state      current FSM state, exported for checkers
//
// Handshake: a single-mode value transfers on a rising clk edge where
//   in_valid && in_ready; in_ready never depends on in_valid, and in_valid
//   offered while in_ready is low is simply not taken (re-offer in IDLE).
module toa_fine_code_generator #(
  parameter int RUN_LEN = 4,
  parameter int HOLD_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_value,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              inj_en,
  input  logic [5:0]        inj_bit,
  output logic [62:0]       code_out,
  output logic              code_valid,
  output logic [5:0]        code_value,
  output logic              code_injected,
  output logic              sweep_wrap,
  output logic [2:0]        dbg_state
);

  if (RUN_LEN < 1 || RUN_LEN > 8) begin : g_bad_run_len
    $error("toa_fine_code_generator: RUN_LEN must be in 1..8");
  end

  // RUN_LEN ones at the bottom, duplicated so a rotate is a plain slice.
  localparam logic [62:0]  BASE = 63'((64'd1 << RUN_LEN) - 64'd1);
  localparam logic [125:0] DUP  = {BASE, BASE};

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_HOLD       = 3'd2,
    S_SWEEP_LOAD = 3'd3,
    S_SWEEP_HOLD = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [5:0]        cap_value;
  logic              cap_inj_en;
  logic [5:0]        cap_inj_bit;
  logic [5:0]        sweep_cnt;
  logic              wrap_pend;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;

  logic [5:0]        launch_n;
  logic              launch_en;
  logic [5:0]        launch_bit;
  logic [6:0]        rot_sh;
  logic [62:0]       word_nom;
  logic              launch_hit;
  logic [62:0]       word_launch;

  assign dbg_state = state;
  assign hold_done = (hold_cnt == '0);

  // Next state and in_ready. Mode is only consulted in IDLE and at hold
  // expiry, so a mode change never truncates a word.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = (mode == 2'b01) && !rst;
        if (mode == 2'b01 && in_valid)      state_next = S_LOAD;
        else if (mode == 2'b10 && in_valid) state_next = S_SWEEP_LOAD;
      end
      S_LOAD:       state_next = S_HOLD;
      S_SWEEP_LOAD: state_next = S_SWEEP_HOLD;
      S_HOLD:       if (hold_done) state_next = S_IDLE;
      S_SWEEP_HOLD: if (hold_done) state_next = (mode == 2'b10) ? S_SWEEP_LOAD : S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  // Word builder: rotate left by N over 63 bits via a 7-bit slice offset,
  // then apply the optional bubble.
  always_comb begin
    launch_n   = cap_value;
    launch_en  = cap_inj_en;
    launch_bit = cap_inj_bit;
    if (state == S_SWEEP_LOAD) begin
      launch_n   = sweep_cnt;
      launch_en  = inj_en;
      launch_bit = inj_bit;
    end
    rot_sh      = 7'd63 - {1'b0, launch_n};
    word_nom    = (launch_n == 6'd63) ? '0 : DUP[rot_sh +: 63];
    launch_hit  = launch_en && (launch_bit != 6'd63);
    word_launch = word_nom ^ (launch_hit ? (63'd1 << launch_bit) : 63'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cap_value     <= '0;
      cap_inj_en    <= 1'b0;
      cap_inj_bit   <= '0;
      sweep_cnt     <= '0;
      wrap_pend     <= 1'b0;
      hold_cnt      <= '0;
      code_out      <= '0;
      code_valid    <= 1'b0;
      code_value    <= '0;
      code_injected <= 1'b0;
      sweep_wrap    <= 1'b0;
    end else begin
      state      <= state_next;
      sweep_wrap <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mode == 2'b01 && in_valid) begin
            cap_value   <= in_value;
            cap_inj_en  <= inj_en;
            cap_inj_bit <= inj_bit;
          end else if (mode == 2'b10 && in_valid) begin
            sweep_cnt <= (in_value == 6'd63) ? 6'd0 : in_value;
            wrap_pend <= 1'b0;
          end
        end
        S_LOAD, S_SWEEP_LOAD: begin
          code_out      <= word_launch;
          code_value    <= launch_n;
          code_injected <= launch_hit;
          code_valid    <= 1'b1;
          hold_cnt      <= hold_cycles;
          if (state == S_SWEEP_LOAD) begin
            sweep_wrap <= wrap_pend;
            wrap_pend  <= 1'b0;
          end
        end
        S_HOLD, S_SWEEP_HOLD: begin
          if (hold_done) begin
            code_valid <= 1'b0;
            if (state == S_SWEEP_HOLD) begin
              sweep_cnt <= (sweep_cnt == 6'd62) ? 6'd0 : 6'(sweep_cnt + 6'd1);
              wrap_pend <= (sweep_cnt == 6'd62);
            end
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
